// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for a multicycle RISC-V core with memory-wait timeout and trap reporting.
// Optional: define BRANCH_EXT_EN to accept bne alongside beq.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TIMEOUT_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       memread,
  output logic       memwrite,
  output logic       adrsrc,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] immsrc,
  output logic [2:0] alucontrol,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10,
    S_JAL      = 4'd11,
    S_TRAP     = 4'd12
  } state_t;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  state_t cur, nxt;
  logic [TIMEOUT_W-1:0] cnt, cnt_nxt;
  logic [1:0] cause, cause_nxt;
  logic [2:0] funct_alu;
  logic waiting, timeout, br_ok, br_taken;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur   <= S_RESET;
      cnt   <= '0;
      cause <= 2'b00;
    end else begin
      cur   <= nxt;
      cnt   <= cnt_nxt;
      cause <= cause_nxt;
    end
  end
  assign state      = cur;
  assign trap_cause = cause;
  assign funct_alu  = funct3 == 3'b000 ? ((op[5] & funct7b5) ? ALU_SUB : ALU_ADD) :
                      funct3 == 3'b010 ? 3'b101 :
                      funct3 == 3'b110 ? 3'b011 :
                      funct3 == 3'b111 ? 3'b010 : ALU_ADD;
`ifdef BRANCH_EXT_EN
  assign br_ok    = funct3 == 3'b000 || funct3 == 3'b001;
  assign br_taken = funct3[0] ? ~zero : zero;
`else
  assign br_ok    = funct3 == 3'b000;
  assign br_taken = zero;
`endif
  assign immsrc = cur == S_RESET     ? 2'b00 :
                  op == 7'b0100011   ? 2'b01 :
                  op == 7'b1100011   ? 2'b10 :
                  op == 7'b1101111   ? 2'b11 : 2'b00;
  assign waiting = cur == S_FETCH || cur == S_MEMREAD || cur == S_MEMWRITE;
  assign timeout = waiting && !mem_ready && cnt == TIMEOUT_W'(MEM_TIMEOUT);
  // The counter restarts whenever the state moves, so each access gets a fresh budget.
  assign cnt_nxt = (waiting && !mem_ready && nxt == cur) ? cnt + 1'b1 : '0;
  always_comb begin
    nxt        = cur;
    cause_nxt  = cause;
    memread    = 1'b0;
    memwrite   = 1'b0;
    adrsrc     = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    regwrite   = 1'b0;
    resultsrc  = 2'b00;
    alusrca    = 2'b00;
    alusrcb    = 2'b00;
    alucontrol = ALU_ADD;
    trap       = 1'b0;
    case (cur)
      S_RESET: nxt = S_FETCH;
      S_FETCH: begin
        memread   = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        irwrite   = mem_ready;
        pcwrite   = mem_ready;
        nxt       = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: nxt = S_MEMADR;
          7'b0110011:             nxt = S_EXECR;
          7'b0010011:             nxt = S_EXECI;
          7'b1101111:             nxt = S_JAL;
          7'b1100011:             nxt = br_ok ? S_BEQ : S_TRAP;
          default:                nxt = S_TRAP;
        endcase
        cause_nxt = nxt == S_TRAP ? 2'b01 : cause;
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        nxt     = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        memread = 1'b1;
        adrsrc  = 1'b1;
        nxt     = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        resultsrc = 2'b01;
        regwrite  = 1'b1;
        nxt       = S_FETCH;
      end
      S_MEMWRITE: begin
        memwrite = 1'b1;
        adrsrc   = 1'b1;
        nxt      = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alusrca    = 2'b10;
        alucontrol = funct_alu;
        nxt        = S_ALUWB;
      end
      S_EXECI: begin
        alusrca    = 2'b10;
        alusrcb    = 2'b01;
        alucontrol = funct_alu;
        nxt        = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        nxt      = S_FETCH;
      end
      S_JAL: begin
        alusrca = 2'b01;
        alusrcb = 2'b10;
        pcwrite = 1'b1;
        nxt     = S_ALUWB;
      end
      S_BEQ: begin
        alusrca    = 2'b10;
        alucontrol = ALU_SUB;
        pcwrite    = br_taken;
        nxt        = S_FETCH;
      end
      S_TRAP: trap = 1'b1;
      default: nxt = S_RESET;
    endcase
    if (timeout) begin
      nxt       = S_TRAP;
      cause_nxt = 2'b10;
    end
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle successor to the single-cycle control unit: one instruction executes over 3–5 states and shares one memory port and one ALU.
- Moore FSM plus a registered memory-wait handshake with a timeout. It contains the same ALU-decode rules as the single-cycle unit.
- Sits between the instruction register, the shared memory interface and the multicycle datapath muxes.
- Adds trap reporting for illegal opcodes and memory timeouts.

Parameters:
- MEM_TIMEOUT, 15: cycles waiting for mem_ready before a timeout trap. Legal range 1 to 2^TIMEOUT_W-1.
- TIMEOUT_W, 4: width of the wait counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- op  in  7  opcode from the instruction register
- funct3  in  3  from the instruction register
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- memread  out  1  read request, held until mem_ready
- memwrite  out  1  write request, held until mem_ready
- adrsrc  out  1  memory address select: 0 = PC, 1 = ALU result register
- irwrite  out  1  load the instruction register
- pcwrite  out  1  update the PC
- regwrite  out  1  register-file write
- resultsrc  out  2  result mux: 00 = ALUOut, 01 = memory data, 10 = ALU result
- alusrca  out  2  ALU A: 00 = PC, 01 = OldPC, 10 = rs1
- alusrcb  out  2  ALU B: 00 = rs2, 01 = imm, 10 = constant 4
- immsrc  out  2  immediate type: I = 00, S = 01, B = 10, J = 11
- alucontrol  out  3  ALU operation
- trap  out  1  core halted
- trap_cause  out  2  01 = illegal instruction, 10 = memory timeout
- state  out  4  current state, for debug

Behaviour:
- State encoding: RESET = 0, FETCH = 1, DECODE = 2, MEMADR = 3, MEMREAD = 4, MEMWB = 5, MEMWRITE = 6, EXECR = 7, EXECI = 8, ALUWB = 9, BEQ = 10, JAL = 11, TRAP = 12.
- Reset (rst_n low): state = RESET, wait counter = 0, trap_cause = 00.
- In RESET all outputs are 0. The first clock after rst_n rises moves to FETCH.
- Outputs are decoded from state. The only combinational inputs to outputs are mem_ready (irwrite, pcwrite in FETCH) and zero (pcwrite in BEQ).
- Unlisted outputs are 0 in every state.

Per-state outputs and next state:
- FETCH: memread = 1, adrsrc = 0, alusrca = 00, alusrcb = 10, alucontrol = add, resultsrc = 10, irwrite = pcwrite = mem_ready. Next: DECODE on mem_ready, else stay.
- DECODE: alusrca = 01, alusrcb = 01, add (computes the branch target). Next state by op:
  - 0000011 / 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 1100011 with funct3 = 000 → BEQ
  - anything else → TRAP with cause 01
- MEMADR: alusrca = 10, alusrcb = 01, add. Next: MEMWRITE if op[5] = 1, else MEMREAD.
- MEMREAD: memread = 1, adrsrc = 1. Next: MEMWB on mem_ready, else stay.
- MEMWB: resultsrc = 01, regwrite = 1. Next: FETCH.
- MEMWRITE: memwrite = 1, adrsrc = 1. Next: FETCH on mem_ready, else stay.
- EXECR: alusrca = 10, alusrcb = 00, alucontrol from funct decode. Next: ALUWB.
- EXECI: alusrca = 10, alusrcb = 01, alucontrol from funct decode. Next: ALUWB.
- ALUWB: resultsrc = 00, regwrite = 1. Next: FETCH.
- JAL: alusrca = 01, alusrcb = 10, add, resultsrc = 00, pcwrite = 1. Next: ALUWB.
- BEQ: alusrca = 10, alusrcb = 00, sub, resultsrc = 00, pcwrite = zero. Next: FETCH.
- TRAP: trap = 1, trap_cause held, all strobes 0. Left only by reset.

immsrc:
- Combinational from op: 0100011 → 01, 1100011 → 10, 1101111 → 11, else 00.

Funct decode (EXECR/EXECI):
- funct3 000: sub (001) if op[5] & funct7b5, else add (000).
- funct3 010: slt (101).
- funct3 110: or (011).
- funct3 111: and (010).
- Any other funct3: add (000), no trap.

Wait counter (memory timeout):
- Increments each cycle in FETCH, MEMREAD or MEMWRITE while mem_ready = 0.
- Clears on mem_ready and on every state change.
- When the counter equals MEM_TIMEOUT and mem_ready = 0, the next state is TRAP with cause 10.
- mem_ready in the same cycle wins over the timeout.

Latency:
- Zero-wait-state memory:
  - R/I-type: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq: 3 cycles
  - jal: 4 cycles
- Each wait cycle adds 1.

Reset mid-operation: forces RESET immediately and drops all strobes asynchronously, including an in-flight memwrite.

Optional Feature:
- BRANCH_EXT_EN defined: op 1100011 with funct3 = 001 (bne) is legal and goes to BEQ state behaviour with pcwrite = ~zero. The funct3 captured from the instruction register selects the polarity.
- BRANCH_EXT_EN undefined: bne goes to TRAP with cause 01.

Test Plan:
- add, mem_ready always 1 → states 1, 2, 7, 9, 1; regwrite = 1 only in ALUWB; alucontrol = 000; op = 0110011, funct7b5 = 1 gives 001.
- lw, mem_ready low 2 cycles in MEMREAD → memread held 3 cycles, adrsrc = 1, then MEMWB with resultsrc = 01; total 7 cycles.
- beq with zero = 1 then zero = 0 → pcwrite = 1 in BEQ for the first, 0 for the second; both return to FETCH.
- op = 0000000 → DECODE then TRAP, trap = 1, trap_cause = 01, strobes 0 indefinitely.
- mem_ready held 0 in FETCH, MEM_TIMEOUT = 3 → TRAP with cause 10 after 4 FETCH cycles. mem_ready asserted on the 4th cycle → DECODE, no trap.
- rst_n pulsed low during MEMWRITE → memwrite drops asynchronously, state = 0, then FETCH one clock after release. bne: traps without BRANCH_EXT_EN; with it, branches when zero = 0.
